// File: rtl/cdc_arb_pkg.sv
// cdc_arb_pkg: shared types, defaults and round-robin pick
// for the cdc_req_arbiter slice.
package cdc_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ_HI,
    REQ_LO
  } state_t;

  localparam int N_REQ_DEF       = 4;
  localparam int DATA_W_DEF      = 8;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int TIMEOUT_DEF     = 64;

  localparam int REQ_MAX = 16;
  localparam int IDX_W   = 4;

  // First set bit at or above ptr, wrapping at n.
  function automatic logic [IDX_W-1:0] rr_pick(
    input logic [REQ_MAX-1:0] req,
    input logic [IDX_W-1:0]   ptr,
    input int                 n
  );
    logic [IDX_W-1:0] win;
    logic             found;
    int               idx;
    win   = '0;
    found = 1'b0;
    for (int i = 0; i < REQ_MAX; i++) begin
      if (i < n) begin
        idx = int'(ptr) + i;
        if (idx >= n) idx = idx - n;
        if (!found && req[idx]) begin
          win   = idx[IDX_W-1:0];
          found = 1'b1;
        end
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/cdc_req_arbiter_sync.sv
// ack_synchroniser: brings the far-domain level ack
// into clk_a through a reset-to-0 flop chain.
module ack_synchroniser
  import cdc_arb_pkg::*;
#(
  parameter int STAGES = SYNC_STAGES_DEF
) (
  input  logic clk_a,
  input  logic rst_a,
  input  logic ack_async,
  output logic ack_s
);

  logic [STAGES-1:0] chain;

  // shift the asynchronous ack down the chain
  always_ff @(posedge clk_a or posedge rst_a) begin
    if (rst_a) chain <= '0;
    else       chain <= {chain[STAGES-2:0], ack_async};
  end

  assign ack_s = chain[STAGES-1];

endmodule

// File: rtl/cdc_req_arbiter.sv
// cdc_req_arbiter: round-robin share of one 4-phase req/ack CDC channel.
// Optional REQ_HI watchdog enabled by defining CDC_ARB_TIMEOUT_EN.
module cdc_req_arbiter
  import cdc_arb_pkg::*;
#(
  parameter int N_REQ       = N_REQ_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int TIMEOUT     = TIMEOUT_DEF
) (
  input  logic                    clk_a,
  input  logic                    rst_a,
  input  logic [N_REQ-1:0]        req_a,
  input  logic [N_REQ*DATA_W-1:0] data_a,
  output logic [N_REQ-1:0]        gnt_a,
  output logic [N_REQ-1:0]        done_a,
  output logic                    busy_a,
  output logic                    err_a,
  output logic                    xfer_req,
  output logic [DATA_W-1:0]       xfer_data,
  input  logic                    xfer_ack
);

  if (N_REQ < 2 || N_REQ > REQ_MAX) begin : g_bad_n
    $error("N_REQ must be 2..16");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be >= 2");
  end
  if (TIMEOUT < 1) begin : g_bad_to
    $error("TIMEOUT must be >= 1");
  end

  state_t             state;
  logic               ack_s;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   owner;
  logic [IDX_W-1:0]   win;
  logic [IDX_W-1:0]   win_nxt;
  logic [REQ_MAX-1:0] req_ext;
  logic [DATA_W-1:0]  win_data;

  ack_synchroniser #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk_a    (clk_a),
    .rst_a    (rst_a),
    .ack_async(xfer_ack),
    .ack_s    (ack_s)
  );

  // widen requests and select the winner's data slice
  always_comb begin
    req_ext              = '0;
    req_ext[N_REQ-1:0]   = req_a;
    win_data             = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win == IDX_W'(i)) win_data = data_a[i*DATA_W +: DATA_W];
    end
  end

  assign win     = rr_pick(req_ext, ptr, N_REQ);
  assign win_nxt = (win == IDX_W'(N_REQ-1)) ? '0 : win + 1'b1;
  assign busy_a  = (state != IDLE);

`ifdef CDC_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] tcnt;
  logic          aborted;

  // handshake FSM with REQ_HI watchdog
  always_ff @(posedge clk_a or posedge rst_a) begin
    if (rst_a) begin
      state     <= IDLE;
      ptr       <= '0;
      owner     <= '0;
      gnt_a     <= '0;
      done_a    <= '0;
      err_a     <= 1'b0;
      xfer_req  <= 1'b0;
      xfer_data <= '0;
      tcnt      <= '0;
      aborted   <= 1'b0;
    end else begin
      gnt_a  <= '0;
      done_a <= '0;
      err_a  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (|req_a && !ack_s) begin
            state     <= REQ_HI;
            xfer_req  <= 1'b1;
            xfer_data <= win_data;
            gnt_a     <= N_REQ'(1) << win;
            owner     <= win;
            ptr       <= win_nxt;
            tcnt      <= '0;
            aborted   <= 1'b0;
          end
        end
        REQ_HI: begin
          if (ack_s) begin
            xfer_req <= 1'b0;
            state    <= REQ_LO;
          end else if (tcnt == CW'(TIMEOUT-1)) begin
            err_a    <= 1'b1;
            aborted  <= 1'b1;
            xfer_req <= 1'b0;
            state    <= REQ_LO;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        REQ_LO: begin
          if (!ack_s) begin
            if (!aborted) done_a <= N_REQ'(1) << owner;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign err_a = 1'b0;

  // handshake FSM, REQ_HI waits for ack indefinitely
  always_ff @(posedge clk_a or posedge rst_a) begin
    if (rst_a) begin
      state     <= IDLE;
      ptr       <= '0;
      owner     <= '0;
      gnt_a     <= '0;
      done_a    <= '0;
      xfer_req  <= 1'b0;
      xfer_data <= '0;
    end else begin
      gnt_a  <= '0;
      done_a <= '0;
      unique case (state)
        IDLE: begin
          if (|req_a && !ack_s) begin
            state     <= REQ_HI;
            xfer_req  <= 1'b1;
            xfer_data <= win_data;
            gnt_a     <= N_REQ'(1) << win;
            owner     <= win;
            ptr       <= win_nxt;
          end
        end
        REQ_HI: begin
          if (ack_s) begin
            xfer_req <= 1'b0;
            state    <= REQ_LO;
          end
        end
        REQ_LO: begin
          if (!ack_s) begin
            done_a <= N_REQ'(1) << owner;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`endif

endmodule
